fft_frame_stim: RTL and testbench

- Parametrised test-stimulus source for the FFT datapath. Successor to the free-running counter that fed FFT_Top directly.
- Each frame holds BUFFER_SIZE signed samples of SAMPLE_SIZE bits, generated one sample per cycle from a selectable waveform mode.
- Frames are packed into the flat bitstream layout FFT_Top consumes and delivered over a valid/ready handshake.
- Provides a frame counter and an LED heartbeat for board bring-up.

---
 rtl/fft_frame_stim.sv | 90 +++++++++
 tb/tb_fft_frame_stim.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fft_frame_stim.sv
// fft_frame_stim: frame-based waveform source feeding FFT_Top over valid/ready.
// Define FFT_STIM_NOISE_EN to turn mode 3 into LFSR noise instead of a square wave.
module fft_frame_stim #(
  parameter int SAMPLE_SIZE = 32,
  parameter int BUFFER_SIZE = 8,
  parameter int AMPLITUDE   = 1000,
  parameter int CONST_VALUE = 72,
  parameter int LED_BIT     = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [1:0]                      mode,
  output logic [SAMPLE_SIZE*BUFFER_SIZE-1:0] frame_out,
  output logic                            frame_valid,
  input  logic                            frame_ready,
  output logic [15:0]                     frame_count,
  output logic                            led
);
  localparam int IW = $clog2(BUFFER_SIZE);
  localparam int FW = SAMPLE_SIZE * BUFFER_SIZE;
  localparam logic [SAMPLE_SIZE-1:0] AMP  = SAMPLE_SIZE'(AMPLITUDE);
  localparam logic [SAMPLE_SIZE-1:0] NAMP = SAMPLE_SIZE'(-AMPLITUDE);
  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
  state_t state, state_nx;
  logic [1:0] mode_q;
  logic [IW-1:0] idx;
  logic [SAMPLE_SIZE-1:0] ramp_base, sample, alt;
  logic [FW-1:0] stage, stage_nx;
  logic last, accept, start;
  assign last   = idx == IW'(BUFFER_SIZE - 1);
  assign accept = state == HOLD && frame_ready;
  assign start  = state_nx == FILL && state != FILL;
  assign led    = frame_count[LED_BIT];
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (enable ? FILL : IDLE) :
               (state == FILL) ? (last ? HOLD : FILL) :
               (frame_ready ? (enable ? FILL : IDLE) : HOLD);
  end
`ifdef FFT_STIM_NOISE_EN
  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam logic [31:0] SEED = 32'hACE1_0001;
  logic [31:0] lfsr;
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= SEED;
    else if (state == FILL && mode_q == 2'd3) lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'd0);
  assign alt = lfsr[SAMPLE_SIZE-1:0];
`else
  assign alt = idx[0] ? NAMP : AMP;
`endif
  always_comb begin
    sample = (mode_q == 2'd0) ? ramp_base + SAMPLE_SIZE'(idx) :
             (mode_q == 2'd1) ? SAMPLE_SIZE'(CONST_VALUE) :
             (mode_q == 2'd2) ? ((idx == '0) ? AMP : '0) : alt;
    stage_nx = stage;
    stage_nx[idx*SAMPLE_SIZE +: SAMPLE_SIZE] = sample;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode_q      <= '0;
      idx         <= '0;
      ramp_base   <= '0;
      stage       <= '0;
      frame_out   <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
    end else begin
      if (start) begin
        mode_q <= mode;
        idx    <= '0;
      end
      if (state == FILL) begin
        stage <= stage_nx;
        idx   <= idx + 1'b1;
        if (last) begin
          frame_out   <= stage_nx;
          frame_valid <= 1'b1;
          ramp_base   <= ramp_base + SAMPLE_SIZE'(BUFFER_SIZE);
        end
      end
      if (accept) begin
        frame_valid <= 1'b0;
        frame_count <= frame_count + 16'd1;
      end
    end
endmodule

// File: tb/tb_fft_frame_stim.sv
// tb_fft_frame_stim: directed+random frames on a 32-bit and an 8-bit instance against an arithmetic frame model.
module tb_fft_frame_stim;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b1, frame_ready = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [255:0] out_a;
  logic [63:0] out_b;
  logic valid_a, valid_b, led_a, led_b;
  logic [15:0] cnt_a, cnt_b;
  int ncmp = 0, nfail = 0, nfr = 0, cnt = 0, lat_m = 0;
  bit from_idle = 1'b1;

  always #5 clk = ~clk;

  fft_frame_stim dut_a (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .frame_out(out_a),
    .frame_valid(valid_a), .frame_ready(frame_ready), .frame_count(cnt_a), .led(led_a));

  fft_frame_stim #(.SAMPLE_SIZE(8), .AMPLITUDE(100)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .frame_out(out_b),
    .frame_valid(valid_b), .frame_ready(frame_ready), .frame_count(cnt_b), .led(led_b));

  function automatic logic [255:0] model(int m, longint base, int ss, longint amp);
    logic [255:0] f = '0;
    longint mask = (longint'(1) << ss) - 1;
    for (int k = 0; k < 8; k++) begin
      longint v = (m == 0) ? base + k : (m == 1) ? 72 : (m == 2) ? ((k == 0) ? amp : 0) :
                  ((k % 2 == 0) ? amp : -amp);
      f |= 256'(v & mask) << (k * ss);
    end
    return f;
  endfunction

  task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_frame(int m_next, int hold, bit en_next, bit drop_en);
    int n = 0;
    logic [255:0] snap;
    enable = 1'b1;
    while (!valid_a && n < 40) begin
      @(negedge clk);
      n++;
      if (!valid_a) begin
        mode = 2'($urandom);
        frame_ready = 1'($urandom);
        if (drop_en && n > 2) enable = 1'b0;
      end
    end
    frame_ready = 1'b0;
    if (from_idle) check("latency", 256'(n), 256'(9));
    check("valid_rise_a", 256'(valid_a), 256'(1));
    check("valid_rise_b", 256'(valid_b), 256'(1));
    check("frame_a", out_a, model(lat_m, longint'(nfr) * 8, 32, 1000));
    check("frame_b", 256'(out_b), model(lat_m, longint'(nfr) * 8, 8, 100));
    check("count_at_valid", 256'(cnt_a), 256'(cnt));
    nfr++;
    snap = out_a;
    repeat (hold) begin
      @(negedge clk);
      check("bp_valid", 256'(valid_a), 256'(1));
      check("bp_data", out_a, snap);
      check("bp_count", 256'(cnt_a), 256'(cnt));
    end
    mode = 2'(m_next);
    enable = en_next;
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    cnt = (cnt + 1) % 65536;
    check("count_a", 256'(cnt_a), 256'(cnt));
    check("count_b", 256'(cnt_b), 256'(cnt));
    check("led", 256'(led_a), 256'((cnt >> 3) & 1));
    check("valid_drop", 256'(valid_a), 256'(0));
    lat_m = m_next;
    from_idle = !en_next;
    if (!en_next)
      repeat (3) begin
        @(negedge clk);
        check("idle_valid", 256'(valid_a), 256'(0));
      end
  endtask

  initial begin
    repeat (3) begin
      @(negedge clk);
      check("rst_out", out_a, 256'(0));
      check("rst_valid", 256'(valid_a), 256'(0));
      check("rst_count", 256'(cnt_a), 256'(0));
      check("rst_led", 256'(led_a), 256'(0));
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) do_frame(0, 0, 1'b1, 1'b0);
    do_frame(1, 0, 1'b1, 1'b0);
    do_frame(2, 5, 1'b1, 1'b0);
    do_frame(3, 0, 1'b1, 1'b1);
    do_frame(0, 2, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      int m = (nfr + 1 == 31 || nfr + 1 == 32) ? 0 : int'($urandom_range(0, 3));
      do_frame(m, int'($urandom_range(0, 3)), $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0);
    end
    begin
      int n = 0;
      enable = 1'b1;
      while (!valid_a && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("pre_rst_valid", 256'(valid_a), 256'(1));
    end
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", 256'(valid_a), 256'(0));
    check("async_rst_count", 256'(cnt_a), 256'(0));
    check("async_rst_out", out_a, 256'(0));
    @(negedge clk);
    mode = 2'd0;
    enable = 1'b1;
    rst = 1'b0;
    nfr = 0;
    cnt = 0;
    lat_m = 0;
    from_idle = 1'b1;
    do_frame(0, 1, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
